// File: rtl/datamemory_core.sv
// Single-port word-addressed data memory with a registered, write-through read port.
// The array has no reset path; only the read register is cleared by rst_n.
module datamemory_core #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    // Power-up contents come from the declaration initialiser, never from reset.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] rdata_q;

    // Single write port; a reset cycle blocks the write.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            mem_q[address] <= dataIn;
        end
    end

    // Registered read port, write-first on a simultaneous write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (we) begin
            rdata_q <= dataIn;
        end else begin
            rdata_q <= mem_q[address];
        end
    end

    assign dataOut = rdata_q;

endmodule

// File: tb/tb_datamemory_core.sv
// Self-checking bench for datamemory_core: directed vector table, mid-cycle
// corner sequence and randomized traffic against an array-based reference.
module tb_datamemory_core;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] address;
    logic          we;
    logic [DW-1:0] dataIn;
    logic [DW-1:0] dataOut;

    datamemory_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .address (address),
        .we      (we),
        .dataIn  (dataIn),
        .dataOut (dataOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t          tbl [1100];
    int            n_vec;
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_out;
    bit            chk_stable = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] exp);
        n_checks++;
        if (dataOut !== exp) begin
            n_fail++;
            $display("FAIL %s: dataOut=%h expected=%h at %0t", name, dataOut, exp, $time);
        end
    endtask

    // Reference behaviour of one rising edge, from the memory's rules.
    task automatic ref_edge(input logic r, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d);
        if (!r) begin
            ref_out = '0;
        end else if (w) begin
            ref_mem[a] = d;
            ref_out    = d;
        end else begin
            ref_out = ref_mem[a];
        end
    endtask

    // Drive inputs at the falling edge, sample 1 time unit after the rising edge.
    task automatic drive(input logic r, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        @(negedge clk);
        rst_n   = r;
        we      = w;
        address = a;
        dataIn  = d;
        if (chk_stable) begin
            #1;
            check("hold_between_edges", ref_out);
        end
        @(posedge clk);
        #1;
        ref_edge(r, w, a, d);
    endtask

    task automatic add_vec(input logic r, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [DW-1:0] e);
        tbl[n_vec] = '{rst_n: r, we: w, addr: a, din: d, exp: e};
        n_vec++;
    endtask

    initial begin
        logic [DW-1:0] pat;
        logic [AW-1:0] ra;
        logic          rr;
        logic          rw;
        logic [DW-1:0] rd;

        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
        ref_out = '0;

        // Directed table.
        n_vec = 0;
        for (int k = 0; k < 10; k++) begin
            pat = DW'(k) * 32'h1111_1111 + 32'h1;
            add_vec(1'b1, 1'b1, AW'(k), pat, pat);
        end
        for (int k = 0; k < 10; k++) begin
            pat = DW'(k) * 32'h1111_1111 + 32'h1;
            add_vec(1'b1, 1'b0, AW'(k), 32'h0, pat);
        end
        for (int k = 10; k < int'(DEPTH); k++) add_vec(1'b1, 1'b0, AW'(k), 32'h0, 32'h0);
        add_vec(1'b1, 1'b1, AW'(5),    32'hDEAD_BEEF, 32'hDEAD_BEEF);
        add_vec(1'b1, 1'b0, AW'(5),    32'h0,         32'hDEAD_BEEF);
        add_vec(1'b1, 1'b1, AW'(1023), 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        add_vec(1'b0, 1'b1, AW'(1023), 32'hFFFF_FFFF, 32'h0);
        add_vec(1'b1, 1'b0, AW'(1023), 32'h0,         32'hA5A5_A5A5);
        add_vec(1'b1, 1'b1, AW'(3),    32'h1,         32'h1);
        add_vec(1'b1, 1'b1, AW'(3),    32'h2,         32'h2);
        add_vec(1'b1, 1'b0, AW'(3),    32'h0,         32'h2);

        // Power-up reset for two edges.
        drive(1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b0, '0, '0);
        check("reset_dataout", 32'h0);

        // Power-up contents are zero at every address.
        for (int k = 0; k < int'(DEPTH); k++) begin
            drive(1'b1, 1'b0, AW'(k), 32'h0);
            check("powerup_zero", 32'h0);
        end

        for (int i = 0; i < n_vec; i++) begin
            drive(tbl[i].rst_n, tbl[i].we, tbl[i].addr, tbl[i].din);
            check($sformatf("vec%0d_a%0d", i, tbl[i].addr), tbl[i].exp);
        end

        // Address toggled between edges; only the value present at the edge counts.
        drive(1'b1, 1'b0, AW'(8), 32'h0);
        check("pre_toggle_read8", 32'h8888_8889);
        @(negedge clk);
        address = AW'(7);
        #1 address = AW'(8);
        #1 address = AW'(7);
        #1 check("no_comb_path", 32'h8888_8889);
        address = AW'(9);
        dataIn  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        ref_edge(1'b1, 1'b0, AW'(9), 32'hFFFF_FFFF);
        check("toggle_read9", 32'h9999_999A);

        // Randomized traffic against the reference array.
        chk_stable = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 31) != 0);
            rw = $urandom_range(0, 1) == 1;
            ra = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            rd = DW'($urandom);
            drive(rr, rw, ra, rd);
            check("random", ref_out);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/datamemory_core.md
DATAMEMORY_CORE -- requirements
Module: datamemory

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; clock port clk, reset port rst_n.
REQ-002 Parameter DATA_WIDTH SHALL default to 32 and set the word width in bits.
REQ-003 Parameter ADDR_WIDTH SHALL default to 10 and set the address width; depth SHALL be 2**ADDR_WIDTH words (1024 by default).
REQ-004 clk  input  1  SHALL be the rising-edge clock for all state.
REQ-005 rst_n  input  1  SHALL be the synchronous active-low reset, sampled on the clk rising edge.
REQ-006 address  input  ADDR_WIDTH  SHALL be the word address for both read and write.
REQ-007 we  input  1  SHALL be the write enable, active high.
REQ-008 dataIn  input  DATA_WIDTH  SHALL be the write data.
REQ-009 dataOut  output  DATA_WIDTH  SHALL be the registered read data.

Function
REQ-010 Storage SHALL be a single-port array of 2**ADDR_WIDTH words of DATA_WIDTH bits, word-addressed.
REQ-011 Every word SHALL power up as all-zero via an initialiser; no reset path to the array.
REQ-012 On a rising clk edge with rst_n=1 and we=1, mem[address] SHALL take dataIn.
REQ-013 Read SHALL be synchronous: on every rising clk edge with rst_n=1, dataOut SHALL take the word at address, 1-cycle latency.
REQ-014 Read-during-write (we=1) SHALL be write-through: dataOut SHALL take dataIn in that cycle.
REQ-015 With we=0 the array SHALL be unchanged; dataOut SHALL reflect mem[address] one edge later.
REQ-016 Address SHALL be used unmodified; every value 0..2**ADDR_WIDTH-1 valid, no wrap or out-of-range case.
REQ-017 Changes to address, we or dataIn between edges SHALL have no effect until the next rising edge; no combinational path from inputs to dataOut.
REQ-018 Consecutive writes to the same address SHALL keep the last written value.
REQ-019 Array and dataOut SHALL be infer-friendly (single write port, one registered read port) for FPGA block RAM.

Reset
REQ-020 On a rising clk edge with rst_n=0, dataOut SHALL become 0.
REQ-021 Reset SHALL take priority over we: a write in a reset cycle SHALL be blocked, array unchanged.
REQ-022 Reset SHALL NOT clear array contents; data written before reset SHALL be readable after it.
REQ-023 Reset asserted mid-operation SHALL take effect at the next edge only; the first edge with rst_n=1 SHALL resume normal read/write.

Verification
REQ-024 Power-up, rst_n=0 for 2 edges, then we=0 with address stepping 0..1023, one per edge -> dataOut=0 at every address, one cycle behind address.
REQ-025 we=1, dataIn=k*0x11111111+1 at address k for k=0..9; then we=0, read 0..9 -> dataOut equals the written pattern, 1-cycle latency; addresses 10..1023 read 0.
REQ-026 we=1, address=5, dataIn=0xDEADBEEF -> dataOut=0xDEADBEEF after that same edge (write-through).
REQ-027 Write 0xA5A5A5A5 to 1023, assert rst_n=0 one edge with we=1, dataIn=0xFFFFFFFF, address=1023 -> dataOut=0; then read 1023 -> 0xA5A5A5A5.
REQ-028 Write 0x1 then 0x2 to address 3 on consecutive edges, then read 3 -> dataOut=0x00000002.
REQ-029 With we=0, toggle address mid-cycle 7->8->7 between edges, then 9 at the edge -> dataOut shows only mem[9] after the edge.
